// File: rtl/h2f_axi_mem_arbiter.sv
// h2f_axi_mem_arbiter
// AXI3 slave for the HPS-to-FPGA bridge. It arbitrates the write group (AW/W/B) and the read
// group (AR/R) onto a single-port, word-addressed memory request interface. Bursts are
// serialised into one memory access per beat. Unsupported transfers get SLVERR and do not
// touch memory.
//
// Ports:
//   clk_i, reset_i            single clock, synchronous active-high reset
//   aw*_i / awready_o         write address channel (lock/cache/prot not connected)
//   w*_i / wready_o           write data channel (wid not connected)
//   b*_o / bready_i           write response channel
//   ar*_i / arready_o         read address channel
//   r*_o / rready_i           read data channel
//   mem_req_o .. mem_be_o     memory request; accepted in the cycle mem_gnt_i is high
//   mem_rvalid_i, mem_rdata_i read return, at least one cycle after the grant
module h2f_axi_mem_arbiter #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 12
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // write address
  input  logic [ID_W-1:0]     awid_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [3:0]          awlen_i,
  input  logic [2:0]          awsize_i,
  input  logic [1:0]          awburst_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  // write data
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wlast_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  // write response
  output logic [ID_W-1:0]     bid_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  // read address
  input  logic [ID_W-1:0]     arid_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic [3:0]          arlen_i,
  input  logic [2:0]          arsize_i,
  input  logic [1:0]          arburst_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  // read data
  output logic [ID_W-1:0]     rid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rlast_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  // memory side
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-4:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned MemAw = ADDR_W - 3;
  localparam int unsigned StrbW = DATA_W / 8;

  localparam logic GrantWrite = 1'b0;
  localparam logic GrantRead  = 1'b1;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrMem,
    StWrResp,
    StRdMem,
    StRdWait,
    StRdResp
  } state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic [ID_W-1:0]    id_q;
  logic [MemAw-1:0]   addr_q;
  logic [4:0]         beats_q;   // beats still to complete, including the current one
  logic               fixed_q;
  logic               err_q;     // unsupported transfer: no memory accesses
  logic               slverr_q;  // response to report for the current burst
  logic [DATA_W-1:0]  wdata_q;
  logic [StrbW-1:0]   wstrb_q;
  logic [DATA_W-1:0]  rdata_q;

  logic             grant_w;
  logic             grant_r;
  logic             aw_err;
  logic             ar_err;
  logic             last_beat;
  logic [MemAw-1:0] next_addr;

  // Sub-word byte-address bits carry no information for a word-addressed memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{awaddr_i[2:0], araddr_i[2:0]};

  // On a tie the side that did not win last time gets the grant.
  assign grant_w   = awvalid_i && (!arvalid_i || (last_grant_q == GrantRead));
  assign grant_r   = arvalid_i && !grant_w;
  assign aw_err    = (awsize_i != 3'd3) || (awburst_i == BurstWrap);
  assign ar_err    = (arsize_i != 3'd3) || (arburst_i == BurstWrap);
  assign last_beat = (beats_q == 5'd1);
  assign next_addr = fixed_q ? addr_q : addr_q + 1'b1;

  assign awready_o   = (state_q == StIdle) && grant_w;
  assign arready_o   = (state_q == StIdle) && grant_r;
  assign wready_o    = (state_q == StWrData);
  assign bvalid_o    = (state_q == StWrResp);
  assign bid_o       = id_q;
  assign bresp_o     = {slverr_q, 1'b0};
  assign rvalid_o    = (state_q == StRdResp);
  assign rid_o       = id_q;
  assign rdata_o     = rdata_q;
  assign rresp_o     = {slverr_q, 1'b0};
  assign rlast_o     = (state_q == StRdResp) && last_beat;
  assign mem_req_o   = (state_q == StWrMem) || (state_q == StRdMem);
  assign mem_we_o    = (state_q == StWrMem);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = wstrb_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      last_grant_q <= GrantRead;
      id_q         <= '0;
      addr_q       <= '0;
      beats_q      <= '0;
      fixed_q      <= 1'b0;
      err_q        <= 1'b0;
      slverr_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_w) begin
            last_grant_q <= GrantWrite;
            id_q         <= awid_i;
            addr_q       <= awaddr_i[ADDR_W-1:3];
            beats_q      <= {1'b0, awlen_i} + 5'd1;
            fixed_q      <= (awburst_i == BurstFixed);
            err_q        <= aw_err;
            slverr_q     <= aw_err;
            state_q      <= StWrData;
          end else if (grant_r) begin
            last_grant_q <= GrantRead;
            id_q         <= arid_i;
            addr_q       <= araddr_i[ADDR_W-1:3];
            beats_q      <= {1'b0, arlen_i} + 5'd1;
            fixed_q      <= (arburst_i == BurstFixed);
            err_q        <= ar_err;
            slverr_q     <= ar_err;
            rdata_q      <= '0;
            state_q      <= ar_err ? StRdResp : StRdMem;
          end
        end
        StWrData: begin
          if (wvalid_i) begin
            if (err_q) begin
              // Drain only; the burst ends on wlast whatever its length.
              if (wlast_i) state_q <= StWrResp;
            end else begin
              wdata_q <= wdata_i;
              wstrb_q <= wstrb_i;
              // wlast must coincide with the final beat; an early wlast truncates the burst.
              if (wlast_i != last_beat) slverr_q <= 1'b1;
              if (wlast_i) beats_q <= 5'd1;
              state_q <= StWrMem;
            end
          end
        end
        StWrMem: begin
          if (mem_gnt_i) begin
            if (last_beat) begin
              state_q <= StWrResp;
            end else begin
              beats_q <= beats_q - 5'd1;
              addr_q  <= next_addr;
              state_q <= StWrData;
            end
          end
        end
        StWrResp: begin
          if (bready_i) state_q <= StIdle;
        end
        StRdMem: begin
          if (mem_gnt_i) state_q <= StRdWait;
        end
        StRdWait: begin
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            state_q <= StRdResp;
          end
        end
        StRdResp: begin
          if (rready_i) begin
            if (last_beat) begin
              state_q <= StIdle;
            end else begin
              beats_q <= beats_q - 5'd1;
              addr_q  <= next_addr;
              // Error bursts keep returning zero data without touching memory.
              state_q <= err_q ? StRdResp : StRdMem;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_h2f_axi_mem_arbiter.sv
// Self-checking bench for h2f_axi_mem_arbiter: table of transactions with expected response
// and memory-access count, a scoreboard of expected memory ops / B / R beats, and hand
// sequences for reset, arbitration order and reset during a read.
module tb_h2f_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] awid, arid, bid, rid;
  logic [29:0] awaddr, araddr;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [63:0] wdata, rdata, mem_wdata, mem_rdata;
  logic [7:0]  wstrb, mem_be;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [26:0] mem_addr;

  always #5 clk = ~clk;

  h2f_axi_mem_arbiter dut (
    .clk_i(clk), .reset_i(reset),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
    .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
    .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
    .rready_i(rready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    logic [0:0]  wr;
    logic [11:0] id;
    logic [29:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] wbase;
    int          wlast_at;  // beat carrying wlast; beyond len means never asserted
    int          gnt_mode;  // 0: mem_gnt tied high, 1: random
    int          rr_mode;   // 0: rready high, 1: toggling, 2: random
    logic [1:0]  exp_resp;
    int          exp_nmem;
  } vec_t;

  typedef struct { logic we; logic [26:0] addr; logic [63:0] wdata; logic [7:0] be; } mem_op_t;
  typedef struct { logic [11:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [11:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_t;

  mem_op_t mem_wq[$], mem_rq[$];
  b_t      b_q[$];
  r_t      r_q[$];
  int      gnt_order[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, mem_cnt = 0;
  int gnt_mode = 0, rr_mode = 0;
  bit lat_w_en, lat_w_single, lat_r_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mdata(input logic [26:0] a);
    return {5'd0, a, 5'd3, a ^ 27'h5A5A5A5};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model and consumer-side ready generation.
  logic        rv_pend;
  logic [26:0] rv_addr;
  initial forever begin
    @(negedge clk);
    rv_pend = mem_req && mem_gnt && !mem_we && !reset;
    rv_addr = mem_addr;
  end
  initial begin
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; rready = 1'b1; bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = rv_pend;
      mem_rdata  = rv_pend ? mdata(rv_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
      mem_gnt    = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      bready = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pops, stability and latency checks.
  bit          mhold_prev, rstall_prev;
  logic [63:0] mhold_wdata, rstall_data;
  logic [26:0] mhold_addr;
  logic        mhold_we;
  logic [7:0]  mhold_be;
  int          aw_cyc, ar_cyc;
  bit          w_arm1, w_arm2, w_arm3, r_arm1, r_arm2;
  initial forever begin
    mem_op_t op;
    b_t      be;
    r_t      re;
    @(negedge clk);
    if (reset) begin
      mhold_prev = 0; rstall_prev = 0;
      w_arm1 = 0; w_arm2 = 0; w_arm3 = 0; r_arm1 = 0; r_arm2 = 0;
    end else begin
      if (w_arm1 && wready) begin check("wready_latency", cyc - aw_cyc, 1); w_arm1 = 0; end
      if (w_arm2 && mem_req && mem_we) begin
        check("wr_memreq_latency", cyc - aw_cyc, 2); w_arm2 = 0;
      end
      if (w_arm3 && bvalid) begin check("bvalid_latency", cyc - aw_cyc, 3); w_arm3 = 0; end
      if (r_arm1 && mem_req && !mem_we) begin
        check("rd_memreq_latency", cyc - ar_cyc, 1); r_arm1 = 0;
      end
      if (r_arm2 && rvalid) begin check("rvalid_latency", cyc - ar_cyc, 3); r_arm2 = 0; end

      if (mhold_prev) begin
        check("mem_req_held", mem_req, 1);
        check("mem_hold_stable", {mem_we, mem_addr, mem_be, mem_wdata[27:0]},
              {mhold_we, mhold_addr, mhold_be, mhold_wdata[27:0]});
      end
      mhold_prev = mem_req && !mem_gnt;
      mhold_we = mem_we; mhold_addr = mem_addr; mhold_be = mem_be; mhold_wdata = mem_wdata;

      if (rstall_prev) begin
        check("rvalid_held", rvalid, 1);
        check("rdata_stable", rdata, rstall_data);
      end
      rstall_prev = rvalid && !rready;
      rstall_data = rdata;

      if (mem_req && mem_gnt) begin
        mem_cnt++;
        if (mem_we) begin
          if (mem_wq.size() == 0) check("mem_wr_unexpected", mem_addr, 27'h7FFFFFF ^ mem_addr);
          else begin
            op = mem_wq.pop_front();
            check("mem_wr_addr", mem_addr, op.addr);
            check("mem_wr_data", mem_wdata, op.wdata);
            check("mem_wr_be", mem_be, op.be);
          end
        end else begin
          if (mem_rq.size() == 0) check("mem_rd_unexpected", mem_addr, 27'h7FFFFFF ^ mem_addr);
          else begin
            op = mem_rq.pop_front();
            check("mem_rd_addr", mem_addr, op.addr);
          end
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) check("b_unexpected", bvalid, 0);
        else begin
          be = b_q.pop_front();
          check("bid", bid, be.id);
          check("bresp", bresp, be.resp);
        end
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) check("r_unexpected", rvalid, 0);
        else begin
          re = r_q.pop_front();
          check("rid", rid, re.id);
          check("rdata", rdata, re.data);
          check("rresp", rresp, re.resp);
          check("rlast", rlast, re.last);
        end
      end
      if (awvalid && awready) begin
        gnt_order.push_back(0);
        aw_cyc = cyc; w_arm1 = lat_w_en; w_arm2 = lat_w_en; w_arm3 = lat_w_en && lat_w_single;
      end
      if (arvalid && arready) begin
        gnt_order.push_back(1);
        ar_cyc = cyc; r_arm1 = lat_r_en; r_arm2 = lat_r_en;
      end
    end
  end

  task automatic do_write(input vec_t v, input bit chk_cnt);
    bit          err;
    int          nsend, n, m0;
    logic [26:0] word;
    logic [63:0] wd[$];
    mem_op_t     op;
    err = (v.size != 3'd3) || (v.burst == 2'b10);
    if (err || v.wlast_at < int'(v.len)) nsend = v.wlast_at + 1;
    else nsend = int'(v.len) + 1;
    word = v.addr[29:3];
    for (int b = 0; b < nsend; b++) begin
      wd.push_back(v.wbase + 64'(b) * 64'h0101_0101_0101_0101);
      if (!err) begin
        op.we = 1'b1; op.addr = word; op.wdata = wd[b]; op.be = v.strb;
        mem_wq.push_back(op);
      end
      if (v.burst != 2'b00) word = word + 27'd1;
    end
    b_q.push_back('{v.id, v.exp_resp});
    gnt_mode = v.gnt_mode;
    lat_w_en = (v.gnt_mode == 0) && !err;
    lat_w_single = (v.len == 4'd0);
    m0 = mem_cnt;
    awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 200) begin @(negedge clk); n++; end
    if (!awready) check("awready_timeout", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < nsend; b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = v.strb; wlast = (b == v.wlast_at);
      n = 0;
      @(negedge clk);
      while (!wready && n < 200) begin @(negedge clk); n++; end
      if (!wready) check("wready_timeout", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (b_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (b_q.size() != 0) begin check("b_timeout", b_q.size(), 0); b_q.delete(); end
    @(posedge clk); #1;
    if (chk_cnt) check("mem_count_wr", mem_cnt - m0, v.exp_nmem);
  endtask

  task automatic do_read(input vec_t v, input bit chk_cnt);
    bit          err;
    int          n, m0;
    logic [26:0] word;
    mem_op_t     op;
    err = (v.size != 3'd3) || (v.burst == 2'b10);
    word = v.addr[29:3];
    for (int b = 0; b <= int'(v.len); b++) begin
      if (!err) begin
        op.we = 1'b0; op.addr = word; op.wdata = '0; op.be = '0;
        mem_rq.push_back(op);
      end
      r_q.push_back('{v.id, err ? 64'h0 : mdata(word), v.exp_resp, b == int'(v.len)});
      if (v.burst != 2'b00) word = word + 27'd1;
    end
    gnt_mode = v.gnt_mode;
    rr_mode  = v.rr_mode;
    lat_r_en = (v.gnt_mode == 0) && !err;
    m0 = mem_cnt;
    arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 200) begin @(negedge clk); n++; end
    if (!arready) check("arready_timeout", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (r_q.size() != 0 && n < 600) begin @(negedge clk); n++; end
    if (r_q.size() != 0) begin check("r_timeout", r_q.size(), 0); r_q.delete(); end
    @(posedge clk); #1;
    if (chk_cnt) check("mem_count_rd", mem_cnt - m0, v.exp_nmem);
  endtask

  vec_t vecs[12];
  vec_t va, vb;

  initial begin
    //          wr id       addr           len   size  burst strb   wbase
    //          wlast gnt rr resp nmem
    vecs[0]  = '{1'b1, 12'h05A, 30'h0000_0100, 4'd0,  3'd3, 2'd1, 8'hFF, 64'h1122334455667788,
                 0,  0, 0, 2'd0, 1};
    vecs[1]  = '{1'b0, 12'h123, 30'h3FFF_FFF8, 4'd3,  3'd3, 2'd1, 8'h00, 64'h0,
                 0,  0, 1, 2'd0, 4};
    vecs[2]  = '{1'b0, 12'h077, 30'h0000_0040, 4'd1,  3'd2, 2'd1, 8'h00, 64'h0,
                 0,  0, 0, 2'd2, 0};
    vecs[3]  = '{1'b1, 12'h0AB, 30'h0000_0080, 4'd1,  3'd3, 2'd2, 8'hFF, 64'hA0A0_0000_0000_0001,
                 1,  0, 0, 2'd2, 0};
    vecs[4]  = '{1'b1, 12'h011, 30'h0000_0200, 4'd3,  3'd3, 2'd1, 8'hF0, 64'h0BAD_CAFE_0000_1000,
                 1,  0, 0, 2'd2, 2};
    vecs[5]  = '{1'b1, 12'h022, 30'h0000_0300, 4'd1,  3'd3, 2'd1, 8'h0F, 64'h1234_0000_5678_0000,
                 99, 0, 0, 2'd2, 2};
    vecs[6]  = '{1'b1, 12'h033, 30'h0000_2000, 4'd3,  3'd3, 2'd0, 8'h3C, 64'hFEED_0000_0000_0010,
                 3,  1, 0, 2'd0, 4};
    vecs[7]  = '{1'b0, 12'h044, 30'h0000_2008, 4'd2,  3'd3, 2'd0, 8'h00, 64'h0,
                 0,  1, 2, 2'd0, 3};
    vecs[8]  = '{1'b1, 12'hFFF, 30'h3FFF_FFF0, 4'd15, 3'd3, 2'd1, 8'hFF, 64'h0F0F_0000_0000_0100,
                 15, 1, 0, 2'd0, 16};
    vecs[9]  = '{1'b0, 12'h800, 30'h3FFF_FFF0, 4'd15, 3'd3, 2'd1, 8'h00, 64'h0,
                 0,  1, 2, 2'd0, 16};
    vecs[10] = '{1'b1, 12'h155, 30'h0000_0400, 4'd1,  3'd3, 2'd1, 8'h00, 64'h5555_0000_0000_0000,
                 1,  0, 0, 2'd0, 2};
    vecs[11] = '{1'b0, 12'h066, 30'h0000_0000, 4'd0,  3'd3, 2'd2, 8'h00, 64'h0,
                 0,  0, 0, 2'd2, 0};

    reset = 1'b1;
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    arvalid = 0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0;
    lat_w_en = 0; lat_w_single = 0; lat_r_en = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: nothing valid, ready or requested; data outputs cleared.
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", {awready, arready, wready}, 3'b000);
      check("idle_valid", {bvalid, rvalid, rlast}, 3'b000);
      check("idle_mem_req", {mem_req, mem_we}, 2'b00);
      check("idle_ids", {bid, rid, bresp, rresp}, 28'h0);
      check("idle_rdata", rdata, 64'h0);
      check("idle_mem_data", {mem_addr, mem_be}, 35'h0);
      check("idle_mem_wdata", mem_wdata, 64'h0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr == 1'b1) do_write(vecs[i], 1'b1);
      else do_read(vecs[i], 1'b1);
    end

    // Both address channels valid in every idle cycle: grants must alternate W, R, W, R.
    gnt_order.delete();
    gnt_mode = 0; rr_mode = 0;
    va = '{1'b1, 12'h101, 30'h0000_0500, 4'd1, 3'd3, 2'd1, 8'hFF, 64'h0101_0000_0000_0000,
           1, 0, 0, 2'd0, 2};
    vb = '{1'b0, 12'h202, 30'h0000_0600, 4'd1, 3'd3, 2'd1, 8'h00, 64'h0, 0, 0, 0, 2'd0, 2};
    fork
      begin
        do_write(va, 1'b0);
        va.id = 12'h103; va.addr = 30'h0000_0700;
        do_write(va, 1'b0);
      end
      begin
        do_read(vb, 1'b0);
        vb.id = 12'h204; vb.addr = 30'h0000_0800;
        do_read(vb, 1'b0);
      end
    join
    check("grant_count", gnt_order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_order.size()) check($sformatf("grant_order_%0d", i), gnt_order[i], i % 2);
    end

    // Reset while waiting for read data: burst dropped, no R beat ever appears.
    gnt_mode = 0; rr_mode = 0; lat_r_en = 0;
    mem_rq.push_back('{1'b0, 27'h0000ABC, 64'h0, 8'h0});
    arid = 12'h3C3; araddr = 30'h0000_55E0; arlen = 4'd2; arsize = 3'd3; arburst = 2'd1;
    arvalid = 1'b1;
    @(negedge clk);
    check("rst_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rst_rd_mem_req", {mem_req, mem_we}, 2'b10);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_rdwait_no_rvalid", rvalid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_rvalid", rvalid, 0);
      check("post_rst_mem_req", mem_req, 0);
    end
    check("rst_mem_rd_issued", mem_rq.size(), 0);
    check("queues_drained", mem_wq.size() + b_q.size() + r_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
